// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver, 8 data bits, even parity, 1 stop.
// Ports: clk, reset (async, active-low), RxD (async serial in), baud_select[2:0],
//   Rx_EN; outputs Rx_DATA[7:0], Rx_VALID (1-clk strobe), Rx_PERROR, Rx_FERROR,
//   Rx_BUSY (start confirmed .. stop sample).
module uart_receiver #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR,
    output logic       Rx_BUSY
);

    // Ticks per 1/16 bit, rounded to nearest: 10417, 2604, ... , 27 at 50 MHz.
    localparam logic [13:0] NM1_0 = 14'((CLK_HZ + 8 * 300) / (16 * 300) - 1);
    localparam logic [13:0] NM1_1 = 14'((CLK_HZ + 8 * 1200) / (16 * 1200) - 1);
    localparam logic [13:0] NM1_2 = 14'((CLK_HZ + 8 * 4800) / (16 * 4800) - 1);
    localparam logic [13:0] NM1_3 = 14'((CLK_HZ + 8 * 9600) / (16 * 9600) - 1);
    localparam logic [13:0] NM1_4 = 14'((CLK_HZ + 8 * 19200) / (16 * 19200) - 1);
    localparam logic [13:0] NM1_5 = 14'((CLK_HZ + 8 * 38400) / (16 * 38400) - 1);
    localparam logic [13:0] NM1_6 = 14'((CLK_HZ + 8 * 57600) / (16 * 57600) - 1);
    localparam logic [13:0] NM1_7 = 14'((CLK_HZ + 8 * 115200) / (16 * 115200) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic        sync1_q, rx_s_q;
    logic [2:0]  baud_q;
    logic [13:0] cnt_q, cnt_d;
    logic [13:0] nm1;
    logic        baud_chg;
    logic        sample_tick;

    state_t      state_q, state_d;
    logic [3:0]  tick_q, tick_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        busy_q, busy_d;

    always_comb begin
        nm1 = NM1_7;
        case (baud_select)
            3'd0:    nm1 = NM1_0;
            3'd1:    nm1 = NM1_1;
            3'd2:    nm1 = NM1_2;
            3'd3:    nm1 = NM1_3;
            3'd4:    nm1 = NM1_4;
            3'd5:    nm1 = NM1_5;
            3'd6:    nm1 = NM1_6;
            default: nm1 = NM1_7;
        endcase
    end

    // A rate change restarts the divider so the first tick is a full period.
    assign baud_chg    = (baud_select != baud_q);
    assign sample_tick = Rx_EN && !baud_chg && (cnt_q == nm1);

    always_comb begin
        cnt_d = cnt_q + 14'd1;
        if (!Rx_EN || baud_chg || cnt_q >= nm1) begin
            cnt_d = 14'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        busy_d  = busy_q;
        if (!Rx_EN) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else if (sample_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        tick_d  = 4'd0;
                        state_d = S_START;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                S_START: begin
                    if (tick_q == 4'd7) begin
                        tick_d = 4'd0;
                        if (!rx_s_q) begin
                            busy_d  = 1'b1;
                            idx_d   = 3'd0;
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                S_DATA: begin
                    if (tick_q == 4'd15) begin
                        tick_d         = 4'd0;
                        shift_d[idx_q] = rx_s_q;
                        idx_d          = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = S_PARITY;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                S_PARITY: begin
                    if (tick_q == 4'd15) begin
                        tick_d  = 4'd0;
                        par_d   = rx_s_q;
                        state_d = S_STOP;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                S_STOP: begin
                    if (tick_q == 4'd15) begin
                        tick_d  = 4'd0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                        // Framing error wins; parity only judged on a good stop.
                        if (!rx_s_q) begin
                            ferr_d = 1'b1;
                        end else if (par_q != ^shift_q) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            baud_q  <= 3'd0;
            cnt_q   <= 14'd0;
            state_q <= S_IDLE;
            tick_q  <= 4'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= RxD;
            rx_s_q  <= sync1_q;
            baud_q  <= baud_select;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_PERROR = perr_q;
    assign Rx_FERROR = ferr_q;
    assign Rx_BUSY   = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames into uart_receiver with immediate-assert checks.
// Drives RxD on falling edges; a monitor tallies strobes and flag events.
`timescale 1ns/1ps
module tb_uart_receiver;

    logic       clk;
    logic       reset;
    logic       RxD;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_BUSY;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int vcnt = 0;
    int last_vcyc = 0;
    int bv_bad = 0;
    int wide = 0;
    int busy_cyc = 0;
    int ferr_rise = 0;
    int perr_rise = 0;
    int both = 0;
    logic [7:0] vdata [0:31];
    logic prev_v = 1'b0;
    logic prev_b = 1'b0;
    logic prev_f = 1'b0;
    logic prev_p = 1'b0;

    int start_cyc;

    uart_receiver #(.CLK_HZ(50000000)) dut (
        .clk        (clk),
        .reset      (reset),
        .RxD        (RxD),
        .baud_select(baud_select),
        .Rx_EN      (Rx_EN),
        .Rx_DATA    (Rx_DATA),
        .Rx_VALID   (Rx_VALID),
        .Rx_PERROR  (Rx_PERROR),
        .Rx_FERROR  (Rx_FERROR),
        .Rx_BUSY    (Rx_BUSY)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_v <= Rx_VALID;
        prev_b <= Rx_BUSY;
        prev_f <= Rx_FERROR;
        prev_p <= Rx_PERROR;
        if (Rx_VALID) begin
            vdata[vcnt % 32] <= Rx_DATA;
            vcnt <= vcnt + 1;
            last_vcyc <= cyc;
            if (Rx_BUSY || !prev_b) bv_bad <= bv_bad + 1;
        end
        if (Rx_VALID && prev_v) wide <= wide + 1;
        if (Rx_BUSY) busy_cyc <= busy_cyc + 1;
        if (Rx_FERROR && !prev_f) ferr_rise <= ferr_rise + 1;
        if (Rx_PERROR && !prev_p) perr_rise <= perr_rise + 1;
        if (Rx_FERROR && Rx_PERROR) both <= both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int cpb);
        RxD = b;
        repeat (cpb) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s, input int cpb);
        start_cyc = cyc;
        send_bit(1'b0, cpb);
        for (int i = 0; i < 8; i++) send_bit(d[i], cpb);
        send_bit(p, cpb);
        send_bit(s, cpb);
    endtask

    initial begin
        int v0, b0, f0, p0, lat;
        reset = 1'b0;
        RxD = 1'b1;
        Rx_EN = 1'b0;
        baud_select = 3'b111;
        #200;
        chk("rst_data", {24'd0, Rx_DATA}, 32'h00);
        chk("rst_valid", {31'd0, Rx_VALID}, 32'd0);
        chk("rst_perr", {31'd0, Rx_PERROR}, 32'd0);
        chk("rst_ferr", {31'd0, Rx_FERROR}, 32'd0);
        chk("rst_busy", {31'd0, Rx_BUSY}, 32'd0);
        #200;
        @(negedge clk);
        reset = 1'b1;
        Rx_EN = 1'b1;
        repeat (50) @(negedge clk);

        // Good frame 0x17 at 115200 (432 clk/bit), parity 0.
        v0 = vcnt;
        send_frame(8'h17, 1'b0, 1'b1, 432);
        repeat (5) @(negedge clk);
        chk("f17_count", vcnt - v0, 32'd1);
        chk("f17_strobe_data", {24'd0, vdata[v0]}, 32'h17);
        chk("f17_data", {24'd0, Rx_DATA}, 32'h17);
        chk("f17_perr", {31'd0, Rx_PERROR}, 32'd0);
        chk("f17_ferr", {31'd0, Rx_FERROR}, 32'd0);
        chk("f17_busy_edge", bv_bad, 32'd0);
        lat = last_vcyc - start_cyc;
        chk("f17_latency", {31'd0, (lat >= 4536 && lat <= 4566)}, 32'd1);

        // 0x17 with wrong parity.
        v0 = vcnt;
        p0 = perr_rise;
        send_frame(8'h17, 1'b1, 1'b1, 432);
        repeat (5) @(negedge clk);
        chk("perr_flag", {31'd0, Rx_PERROR}, 32'd1);
        chk("perr_ferr", {31'd0, Rx_FERROR}, 32'd0);
        chk("perr_rise", perr_rise - p0, 32'd1);
        chk("perr_nostrobe", vcnt - v0, 32'd0);
        chk("perr_data_hold", {24'd0, Rx_DATA}, 32'h17);

        // Good 0xA5 clears the parity flag.
        v0 = vcnt;
        send_frame(8'hA5, 1'b0, 1'b1, 432);
        repeat (5) @(negedge clk);
        chk("fa5_perr", {31'd0, Rx_PERROR}, 32'd0);
        chk("fa5_count", vcnt - v0, 32'd1);
        chk("fa5_data", {24'd0, vdata[v0]}, 32'hA5);

        // 0x3C with stop bit 0: framing error only, no strobe.
        v0 = vcnt;
        f0 = ferr_rise;
        p0 = perr_rise;
        b0 = both;
        send_frame(8'h3C, 1'b0, 1'b0, 432);
        RxD = 1'b1;
        repeat (600) @(negedge clk);
        chk("ferr_rise", ferr_rise - f0, 32'd1);
        chk("ferr_no_perr", perr_rise - p0, 32'd0);
        chk("ferr_not_both", both - b0, 32'd0);
        chk("ferr_nostrobe", vcnt - v0, 32'd0);
        chk("ferr_data_hold", {24'd0, Rx_DATA}, 32'hA5);
        chk("ferr_busy_idle", {31'd0, Rx_BUSY}, 32'd0);

        // 5-tick low glitch on idle line.
        v0 = vcnt;
        b0 = busy_cyc;
        RxD = 1'b0;
        repeat (135) @(negedge clk);
        RxD = 1'b1;
        repeat (600) @(negedge clk);
        chk("glitch_busy", busy_cyc - b0, 32'd0);
        chk("glitch_nostrobe", vcnt - v0, 32'd0);
        chk("glitch_perr", {31'd0, Rx_PERROR}, 32'd0);
        chk("glitch_ferr", {31'd0, Rx_FERROR}, 32'd0);

        // Drop Rx_EN in the middle of data bit 4 of 0x8F.
        v0 = vcnt;
        send_bit(1'b0, 432);
        send_bit(1'b1, 432);
        send_bit(1'b1, 432);
        send_bit(1'b1, 432);
        send_bit(1'b1, 432);
        RxD = 1'b0;
        repeat (216) @(negedge clk);
        chk("abort_busy_before", {31'd0, Rx_BUSY}, 32'd1);
        Rx_EN = 1'b0;
        @(negedge clk);
        chk("abort_busy_drop", {31'd0, Rx_BUSY}, 32'd0);
        RxD = 1'b1;
        repeat (100) @(negedge clk);
        Rx_EN = 1'b1;
        repeat (100) @(negedge clk);
        chk("abort_nostrobe", vcnt - v0, 32'd0);
        chk("abort_data_hold", {24'd0, Rx_DATA}, 32'hA5);

        // Recovery frame 0x8F (five ones, parity 1).
        v0 = vcnt;
        send_frame(8'h8F, 1'b1, 1'b1, 432);
        repeat (5) @(negedge clk);
        chk("f8f_count", vcnt - v0, 32'd1);
        chk("f8f_data", {24'd0, vdata[v0]}, 32'h8F);
        chk("f8f_perr", {31'd0, Rx_PERROR}, 32'd0);

        // Back-to-back at 57600 (N=54, 864 clk/bit).
        baud_select = 3'b110;
        repeat (100) @(negedge clk);
        v0 = vcnt;
        f0 = ferr_rise;
        p0 = perr_rise;
        send_frame(8'h00, 1'b0, 1'b1, 864);
        send_frame(8'hFF, 1'b0, 1'b1, 864);
        send_frame(8'h55, 1'b0, 1'b1, 864);
        repeat (5) @(negedge clk);
        chk("b2b_count", vcnt - v0, 32'd3);
        chk("b2b_d0", {24'd0, vdata[v0]}, 32'h00);
        chk("b2b_d1", {24'd0, vdata[v0 + 1]}, 32'hFF);
        chk("b2b_d2", {24'd0, vdata[v0 + 2]}, 32'h55);
        chk("b2b_ferr", ferr_rise - f0, 32'd0);
        chk("b2b_perr", perr_rise - p0, 32'd0);

        chk("valid_width", wide, 32'd0);
        chk("busy_at_valid", bv_bad, 32'd0);
        chk("flags_together", both, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
